// File: rtl/fft_uart_pkg.sv
// Shared definitions for the UART <-> FFT framing blocks: default sizes, sample/byte types
// and the frame loader state encoding.
package fft_uart_pkg;

  localparam int unsigned FFT_SIZE_DEF       = 16;
  localparam int unsigned WORD_SIZE_DEF      = 16;
  localparam int unsigned DATA_LENGTH_DEF    = 8;
  localparam int unsigned FRACTION_DEF       = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 8680;

  typedef logic signed [WORD_SIZE_DEF-1:0] sample_t;
  typedef logic        [DATA_LENGTH_DEF-1:0] byte_t;

  typedef enum logic [0:0] {
    LD_FILL = 1'b0,
    LD_FULL = 1'b1
  } loader_state_e;

endpackage

// File: rtl/fft_frame_loader_if.sv
// Byte-in / frame-out bus of the FFT frame loader. The master drives UART bytes and the
// frame ack; the slave (loader) returns the parallel frame and status pulses.
interface fft_frame_loader_if
  import fft_uart_pkg::*;
#(
  parameter int unsigned FFT_SIZE    = FFT_SIZE_DEF,
  parameter int unsigned WORD_SIZE   = WORD_SIZE_DEF,
  parameter int unsigned DATA_LENGTH = DATA_LENGTH_DEF
);
  localparam int unsigned CNT_W = $clog2(FFT_SIZE) + 1;

  logic [DATA_LENGTH-1:0]          i_byte;
  logic                            i_byte_valid;
  logic                            i_frame_ack;
  logic [FFT_SIZE*WORD_SIZE-1:0]   o_samples;
  logic                            o_frame_valid;
  logic [CNT_W-1:0]                o_fill_count;
  logic                            o_overflow;
  logic                            o_timeout;

  modport master (
    output i_byte, i_byte_valid, i_frame_ack,
    input  o_samples, o_frame_valid, o_fill_count, o_overflow, o_timeout
  );

  modport slave (
    input  i_byte, i_byte_valid, i_frame_ack,
    output o_samples, o_frame_valid, o_fill_count, o_overflow, o_timeout
  );

endinterface

// File: rtl/fft_frame_gap_timer.sv
// Inter-byte gap counter: while enabled, counts cycles without byte activity and emits a
// one-cycle combinational pulse on the TIMEOUT_CYCLES-th idle cycle.
module fft_frame_gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 8680
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic activity_i,
  output logic expired_o_c
);
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [GAP_W-1:0] gap_q, gap_d;

  always_comb begin
    gap_d       = gap_q;
    expired_o_c = 1'b0;
    if (!enable_i || activity_i) begin
      gap_d = '0;
    end else if (gap_q == GAP_W'(TIMEOUT_CYCLES - 1)) begin
      gap_d       = '0;
      expired_o_c = 1'b1;
    end else begin
      gap_d = gap_q + GAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap_q <= '0;
    else        gap_q <= gap_d;
  end

endmodule

// File: rtl/fft_frame_loader.sv
// Collects UART bytes into FFT_SIZE fixed-point samples and hands complete frames to the FFT
// over a valid/ack handshake. Define FRAME_TIMEOUT_EN to discard stalled partial frames.
module fft_frame_loader
  import fft_uart_pkg::*;
#(
  parameter int unsigned FFT_SIZE       = FFT_SIZE_DEF,
  parameter int unsigned WORD_SIZE      = WORD_SIZE_DEF,
  parameter int unsigned DATA_LENGTH    = DATA_LENGTH_DEF,
  parameter int unsigned FRACTION       = FRACTION_DEF,
  parameter bit          SIGNED_IN      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic               i_clk,
  input logic               i_rst_n,
  fft_frame_loader_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(FFT_SIZE);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned BUS_W = FFT_SIZE * WORD_SIZE;

  localparam logic [0:0] S_FILL = LD_FILL;
  localparam logic [0:0] S_FULL = LD_FULL;

  if (WORD_SIZE < DATA_LENGTH + FRACTION) begin : g_bad_word_size
    $error("fft_frame_loader: WORD_SIZE must be >= DATA_LENGTH + FRACTION");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("fft_frame_loader: TIMEOUT_CYCLES must be nonzero");
  end

  // Byte -> Q(WORD_SIZE-FRACTION).FRACTION sample
  function automatic logic [WORD_SIZE-1:0] to_sample(input logic [DATA_LENGTH-1:0] b);
    logic [WORD_SIZE-1:0] ext;
    if (SIGNED_IN) ext = WORD_SIZE'($signed(b));
    else           ext = WORD_SIZE'(b);
    return ext << FRACTION;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BUS_W-1:0] fill_q, fill_d;
  logic [BUS_W-1:0] samples_q, samples_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic             timeout_q, timeout_d;
  logic [IDX_W-1:0] wr_idx;
  logic             gap_expired_c;

  assign wr_idx = cnt_q[IDX_W-1:0];

`ifdef FRAME_TIMEOUT_EN
  logic gap_enable;
  assign gap_enable = (state_q == S_FILL) && (cnt_q != '0);

  fft_frame_gap_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .enable_i    (gap_enable),
    .activity_i  (bus.i_byte_valid),
    .expired_o_c (gap_expired_c)
  );
`else
  assign gap_expired_c = 1'b0;
`endif

  // Next state: fill, hand-off copy (copy beats a same-cycle ack), overflow and timeout
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    samples_d  = samples_q;
    valid_d    = valid_q && !bus.i_frame_ack;
    overflow_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      S_FILL: begin
        if (bus.i_byte_valid) begin
          fill_d[int'(wr_idx)*WORD_SIZE +: WORD_SIZE] = to_sample(bus.i_byte);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FFT_SIZE - 1)) state_d = S_FULL;
        end else if (gap_expired_c) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      S_FULL: begin
        if (!valid_q || bus.i_frame_ack) begin
          samples_d = fill_q;
          valid_d   = 1'b1;
          state_d   = S_FILL;
          cnt_d     = '0;
          if (bus.i_byte_valid) begin
            fill_d[WORD_SIZE-1:0] = to_sample(bus.i_byte);
            cnt_d = CNT_W'(1);
          end
        end else if (bus.i_byte_valid) begin
          overflow_d = 1'b1;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_FILL;
      cnt_q      <= '0;
      fill_q     <= '0;
      samples_q  <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      samples_q  <= samples_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.o_samples     = samples_q;
  assign bus.o_frame_valid = valid_q;
  assign bus.o_fill_count  = cnt_q;
  assign bus.o_overflow    = overflow_q;
  assign bus.o_timeout     = timeout_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Randomized self-checking bench for fft_frame_loader against a queue-based frame model;
// builds with or without FRAME_TIMEOUT_EN.
module tb_fft_frame_loader;
  localparam int unsigned N  = 16;
  localparam int unsigned W  = 16;
  localparam int unsigned DL = 8;
  localparam int unsigned FR = 8;
  localparam bit          SGN = 1'b1;
`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned TMO = 100;
`else
  localparam int unsigned TMO = 8680;
`endif
  localparam int unsigned BW = N * W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_frame_loader_if #(.FFT_SIZE(N), .WORD_SIZE(W), .DATA_LENGTH(DL)) bus ();

  fft_frame_loader #(
    .FFT_SIZE(N), .WORD_SIZE(W), .DATA_LENGTH(DL), .FRACTION(FR),
    .SIGNED_IN(SGN), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Reference model: pending frame as a queue, presented frame as an array
  logic [W-1:0] m_pend[$];
  logic [W-1:0] m_out[N];
  bit           m_valid, m_ovf, m_tmo;
`ifdef FRAME_TIMEOUT_EN
  int unsigned  m_idle;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int ovf_seen = 0;
  int tmo_seen = 0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] conv(input logic [DL-1:0] b);
    int v;
    v = SGN ? int'($signed(b)) : int'(b);
    return W'(v * (2 ** FR));
  endfunction

  function automatic logic [BW-1:0] packed_out();
    logic [BW-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = m_out[k];
    return v;
  endfunction

  function automatic void model_reset();
    m_pend.delete();
    for (int k = 0; k < N; k++) m_out[k] = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_tmo   = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    m_idle  = 0;
`endif
  endfunction

  function automatic void model_step(input bit bv, input logic [DL-1:0] b, input bit ack);
    bit nv;
    nv    = m_valid && !ack;
    m_ovf = 1'b0;
    m_tmo = 1'b0;
    if (m_pend.size() == N) begin
      if (!m_valid || ack) begin
        for (int k = 0; k < N; k++) m_out[k] = m_pend[k];
        nv = 1'b1;
        m_pend.delete();
        if (bv) m_pend.push_back(conv(b));
      end else if (bv) begin
        m_ovf = 1'b1;
      end
`ifdef FRAME_TIMEOUT_EN
      m_idle = 0;
`endif
    end else if (bv) begin
      m_pend.push_back(conv(b));
`ifdef FRAME_TIMEOUT_EN
      m_idle = 0;
    end else if (m_pend.size() != 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_pend.delete();
        m_tmo  = 1'b1;
        m_idle = 0;
      end
`endif
    end
    m_valid = nv;
  endfunction

  task automatic compare_all();
    check("frame_valid", BW'(bus.o_frame_valid), BW'(m_valid));
    check("fill_count",  BW'(bus.o_fill_count),  BW'(m_pend.size()));
    check("overflow",    BW'(bus.o_overflow),    BW'(m_ovf));
    check("timeout",     BW'(bus.o_timeout),     BW'(m_tmo));
    check("samples",     bus.o_samples,          packed_out());
    if (bus.o_overflow) ovf_seen++;
    if (bus.o_timeout)  tmo_seen++;
  endtask

  // One clock: drive inputs, advance model, sample 1 time unit after the edge
  task automatic step(input bit bv, input logic [DL-1:0] b, input bit ack);
    bus.i_byte_valid = bv;
    bus.i_byte       = b;
    bus.i_frame_ack  = ack;
    model_step(bv, b, ack);
    @(posedge clk);
    #1;
    compare_all();
    bus.i_byte_valid = 1'b0;
    bus.i_frame_ack  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0);
  endtask

  task automatic send(input logic [DL-1:0] b, input int gap);
    step(1'b1, b, 1'b0);
    idle(gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n            = 1'b0;
    bus.i_byte_valid = 1'b0;
    bus.i_frame_ack  = 1'b0;
    bus.i_byte       = '0;
    #1;
    model_reset();
    check("rst_samples", bus.o_samples, '0);
    check("rst_valid",   BW'(bus.o_frame_valid), '0);
    check("rst_fill",    BW'(bus.o_fill_count), '0);
    check("rst_pulses",  BW'({bus.o_overflow, bus.o_timeout}), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [DL-1:0] bytes_q[$];
  logic [DL-1:0] b;

  initial begin
    bus.i_byte       = '0;
    bus.i_byte_valid = 1'b0;
    bus.i_frame_ack  = 1'b0;
    do_reset();

    // 1: ramp 0x00..0x0F, one byte per 10 cycles, 2-cycle latency
    for (int k = 0; k < N - 1; k++) send(DL'(k), 9);
    step(1'b1, DL'(N - 1), 1'b0);
    check("t1_valid_early", BW'(bus.o_frame_valid), '0);
    step(1'b0, '0, 1'b0);
    check("t1_valid_latency", BW'(bus.o_frame_valid), BW'(1));
    check("t1_fill_zero", BW'(bus.o_fill_count), '0);
    for (int k = 0; k < N; k++)
      check("t1_sample", BW'(bus.o_samples[k*W +: W]), BW'(k << FR));

    // 2: conversion of sign-boundary bytes
    step(1'b0, '0, 1'b1);
    bytes_q = '{8'h80, 8'hFF, 8'h7F};
    for (int k = 3; k < N; k++) bytes_q.push_back(DL'($urandom));
    for (int k = 0; k < N; k++) send(bytes_q[k], int'($urandom_range(0, 2)));
    idle(2);
    check("t2_s0", BW'(bus.o_samples[0 +: W]),   BW'(16'h8000));
    check("t2_s1", BW'(bus.o_samples[W +: W]),   BW'(16'hFF00));
    check("t2_s2", BW'(bus.o_samples[2*W +: W]), BW'(16'h7F00));

    // 3: second frame waits in FULL, extra bytes overflow, ack hands it over
    step(1'b0, '0, 1'b1);
    bytes_q.delete();
    for (int k = 0; k < 2 * N; k++) begin
      b = DL'($urandom);
      bytes_q.push_back(b);
      send(b, int'($urandom_range(0, 3)));
    end
    idle(2);
    ovf_seen = 0;
    for (int k = 0; k < 3; k++) send(DL'($urandom), 1);
    check("t3_overflow_count", BW'(ovf_seen), BW'(3));
    for (int k = 0; k < N; k++)
      check("t3_held_frame", BW'(bus.o_samples[k*W +: W]), BW'({bytes_q[k], 8'h00}));
    step(1'b0, '0, 1'b1);
    check("t3_valid_stays", BW'(bus.o_frame_valid), BW'(1));
    check("t3_fill_zero", BW'(bus.o_fill_count), '0);
    for (int k = 0; k < N; k++)
      check("t3_second_frame", BW'(bus.o_samples[k*W +: W]), BW'({bytes_q[N+k], 8'h00}));

    // 4: reset mid-frame discards the partial frame
    step(1'b0, '0, 1'b1);
    for (int k = 0; k < 7; k++) send(DL'($urandom), 1);
    do_reset();
    bytes_q.delete();
    for (int k = 0; k < N; k++) begin
      b = DL'($urandom);
      bytes_q.push_back(b);
      send(b, 1);
    end
    idle(2);
    check("t4_valid", BW'(bus.o_frame_valid), BW'(1));
    for (int k = 0; k < N; k++)
      check("t4_post_reset", BW'(bus.o_samples[k*W +: W]), BW'({bytes_q[k], 8'h00}));

    // 6: byte in the copy cycle becomes sample 0 of the next frame
    step(1'b0, '0, 1'b1);
    bytes_q.delete();
    for (int k = 0; k < N + 1; k++) begin
      b = DL'($urandom);
      bytes_q.push_back(b);
      send(b, 0);
    end
    check("t6_fill_one", BW'(bus.o_fill_count), BW'(1));
    check("t6_valid", BW'(bus.o_frame_valid), BW'(1));
    for (int k = 0; k < N - 1; k++) send(DL'($urandom), 0);
    step(1'b0, '0, 1'b1);
    check("t6_next_s0", BW'(bus.o_samples[0 +: W]), BW'({bytes_q[N], 8'h00}));

    // 5: inter-byte gap handling (99 idle cycles survive, 100 discard when enabled)
    step(1'b0, '0, 1'b1);
    tmo_seen = 0;
    for (int k = 0; k < 5; k++) send(DL'($urandom), 0);
    idle(99);
    send(DL'($urandom), 0);
    check("t5_no_timeout_99", BW'(tmo_seen), '0);
    check("t5_fill_after_99", BW'(bus.o_fill_count), BW'(6));
    idle(100);
`ifdef FRAME_TIMEOUT_EN
    check("t5_timeout_once", BW'(tmo_seen), BW'(1));
    check("t5_fill_cleared", BW'(bus.o_fill_count), '0);
    for (int k = 0; k < N; k++) send(DL'($urandom), 0);
`else
    check("t5_timeout_never", BW'(tmo_seen), '0);
    check("t5_fill_kept", BW'(bus.o_fill_count), BW'(6));
    for (int k = 0; k < N - 6; k++) send(DL'($urandom), 0);
`endif
    idle(2);
    check("t5_frame_valid", BW'(bus.o_frame_valid), BW'(1));

    // Random traffic with random acks
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 2) == 0, DL'($urandom), $urandom_range(0, 3) == 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
